// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline types for the hazard controller.
`default_nettype none
package hazard_ctrl_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_STALL   = 2'd1,
    FREEZE     = 2'd2,
    FLUSH_PEND = 2'd3
  } hz_state_e;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
`default_nettype none
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller with load-use, memory freeze
// and branch flush handling plus saturating stall/flush event counters.
`default_nettype none
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RD,
  input  logic             Branch_Taken,
  input  logic             Mem_Busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  hz_state_e state_q;
  hz_state_e state_d;
  logic      lu_hit;
  logic      flush_evt;

  assign lu_hit = load_use_hit(ID_EX_MemRead, ID_EX_RD, IF_ID_RS1, IF_ID_RS2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN, LU_STALL: begin
        if (Mem_Busy) begin
          state_d = Branch_Taken ? FLUSH_PEND : FREEZE;
        end else if (Branch_Taken) begin
          state_d = RUN;
        end else if ((state_q == RUN) && lu_hit) begin
          state_d = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      FREEZE: begin
        if (Mem_Busy) begin
          state_d = Branch_Taken ? FLUSH_PEND : FREEZE;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH_PEND: begin
        if (!Mem_Busy) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // A branch that resolves as memory frees up in FREEZE is flushed on the spot.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    flush_evt    = 1'b0;
    if (reset) begin
      if (Mem_Busy) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Write = 1'b0;
      end else if (Branch_Taken || (state_q == FLUSH_PEND)) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
        EX_MEM_Flush = 1'b1;
        flush_evt    = 1'b1;
      end else if ((state_q == RUN) && lu_hit) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (~PC_Write),
    .count_o (Stall_Count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (flush_evt),
    .count_o (Flush_Count)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl.
`default_nettype none
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  IF_ID_RS1, IF_ID_RS2, ID_EX_RD;
  logic        ID_EX_MemRead, Branch_Taken, Mem_Busy;
  logic        PC_Write, IF_ID_Write, ID_EX_Write;
  logic        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush;
  logic [31:0] Stall_Count, Flush_Count;

  hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .IF_ID_RS1    (IF_ID_RS1),
    .IF_ID_RS2    (IF_ID_RS2),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_RD     (ID_EX_RD),
    .Branch_Taken (Branch_Taken),
    .Mem_Busy     (Mem_Busy),
    .PC_Write     (PC_Write),
    .IF_ID_Write  (IF_ID_Write),
    .ID_EX_Write  (ID_EX_Write),
    .IF_ID_Flush  (IF_ID_Flush),
    .ID_EX_Flush  (ID_EX_Flush),
    .EX_MEM_Flush (EX_MEM_Flush),
    .Stall_Count  (Stall_Count),
    .Flush_Count  (Flush_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}
  localparam logic [5:0] C_RUN = 6'b111_000;
  localparam logic [5:0] C_FRZ = 6'b000_000;
  localparam logic [5:0] C_FLS = 6'b111_111;
  localparam logic [5:0] C_LU  = 6'b001_010;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  wire [5:0] ctrl_w = {PC_Write, IF_ID_Write, ID_EX_Write,
                       IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush};

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, check outputs mid-cycle
  // and the counters just after the clock edge.
  task automatic step(input string tag, input logic mb, input logic bt, input logic mr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [5:0] ec, input logic [31:0] es, input logic [31:0] ef);
    exp_t e;
    Mem_Busy = mb; Branch_Taken = bt; ID_EX_MemRead = mr;
    ID_EX_RD = rd; IF_ID_RS1 = rs1; IF_ID_RS2 = rs2;
    sb.push_back('{ctrl: ec, stall: es, flush: ef});
    #3;
    e = sb.pop_front();
    chk_val({tag, "/ctrl"}, {26'd0, ctrl_w}, {26'd0, e.ctrl});
    @(posedge clk); #1;
    chk_val({tag, "/stall"}, Stall_Count, e.stall);
    chk_val({tag, "/flush"}, Flush_Count, e.flush);
  endtask

  // Holds reset low across one edge with busy/branch asserted to show the
  // outputs are forced to run values regardless of inputs.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    Mem_Busy = 1'b1; Branch_Taken = 1'b1; ID_EX_MemRead = 1'b1;
    ID_EX_RD = 5'd5; IF_ID_RS1 = 5'd5; IF_ID_RS2 = 5'd0;
    #2;
    chk_val({tag, "/rst_ctrl"}, {26'd0, ctrl_w}, {26'd0, C_RUN});
    chk_val({tag, "/rst_stall"}, Stall_Count, 32'd0);
    chk_val({tag, "/rst_flush"}, Flush_Count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    Mem_Busy = 1'b0; Branch_Taken = 1'b0; ID_EX_MemRead = 1'b0;
    ID_EX_RD = 5'd0; IF_ID_RS1 = 5'd0; IF_ID_RS2 = 5'd0;
    @(posedge clk); #1;
    do_reset("init");

    // load-use: stall one cycle, then proceed
    step("lu1",  0, 0, 1, 5'd5, 5'd5, 5'd0, C_LU,  1, 0);
    step("lu2",  0, 0, 1, 5'd5, 5'd5, 5'd0, C_RUN, 1, 0);
    step("lu3",  0, 0, 0, 5'd0, 5'd0, 5'd0, C_RUN, 1, 0);
    step("lurs2",0, 0, 1, 5'd9, 5'd1, 5'd9, C_LU,  2, 0);
    step("lurs2b",0,0, 0, 5'd0, 5'd0, 5'd0, C_RUN, 2, 0);

    // x0 destination never stalls
    do_reset("x0");
    step("x0a", 0, 0, 1, 5'd0, 5'd0, 5'd0, C_RUN, 0, 0);
    step("x0b", 0, 0, 1, 5'd0, 5'd3, 5'd0, C_RUN, 0, 0);
    step("nomr",0, 0, 0, 5'd7, 5'd7, 5'd7, C_RUN, 0, 0);

    // branch in RUN
    do_reset("br");
    step("br1", 0, 1, 0, 5'd0, 5'd0, 5'd0, C_FLS, 0, 1);
    step("br2", 0, 0, 0, 5'd0, 5'd0, 5'd0, C_RUN, 0, 1);

    // branch arriving during a memory freeze
    do_reset("frz");
    step("frz1", 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FRZ, 1, 0);
    step("frz2", 1, 1, 0, 5'd0, 5'd0, 5'd0, C_FRZ, 2, 0);
    step("frz3", 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FRZ, 3, 0);
    step("frz4", 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FRZ, 4, 0);
    step("frz5", 0, 0, 0, 5'd0, 5'd0, 5'd0, C_FLS, 4, 1);
    step("frz6", 0, 0, 0, 5'd0, 5'd0, 5'd0, C_RUN, 4, 1);

    // plain freeze, no branch
    step("pf1", 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FRZ, 5, 1);
    step("pf2", 0, 0, 0, 5'd0, 5'd0, 5'd0, C_RUN, 5, 1);

    // busy + branch + load-use together: freeze wins, flush later, no LU_STALL
    do_reset("sim");
    step("sim1", 1, 1, 1, 5'd5, 5'd5, 5'd0, C_FRZ, 1, 0);
    step("sim2", 1, 0, 1, 5'd5, 5'd5, 5'd0, C_FRZ, 2, 0);
    step("sim3", 0, 0, 1, 5'd5, 5'd5, 5'd0, C_FLS, 2, 1);
    step("sim4", 0, 0, 0, 5'd0, 5'd0, 5'd0, C_RUN, 2, 1);

    // events during LU_STALL are handled, hazard detection is suppressed
    do_reset("lus");
    step("lus1", 0, 0, 1, 5'd4, 5'd4, 5'd0, C_LU,  1, 0);
    step("lus2", 0, 1, 1, 5'd4, 5'd4, 5'd0, C_FLS, 1, 1);
    step("lus3", 0, 0, 1, 5'd4, 5'd4, 5'd0, C_LU,  2, 1);
    step("lus4", 1, 0, 1, 5'd4, 5'd4, 5'd0, C_FRZ, 3, 1);
    step("lus5", 0, 0, 0, 5'd0, 5'd0, 5'd0, C_RUN, 3, 1);

    // reset in FLUSH_PEND discards the pending flush
    step("fpr1", 1, 1, 0, 5'd0, 5'd0, 5'd0, C_FRZ, 4, 1);
    do_reset("fpr");
    step("fpr2", 0, 0, 0, 5'd0, 5'd0, 5'd0, C_RUN, 0, 0);
    step("fpr3", 0, 0, 0, 5'd0, 5'd0, 5'd0, C_RUN, 0, 0);

    // saturation of the stall counter from a preloaded value
    force dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count_q;
    step("sat1", 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FRZ, 32'hFFFF_FFFF, 0);
    step("sat2", 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FRZ, 32'hFFFF_FFFF, 0);
    step("sat3", 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FRZ, 32'hFFFF_FFFF, 0);
    step("sat4", 0, 0, 0, 5'd0, 5'd0, 5'd0, C_RUN, 32'hFFFF_FFFF, 0);

    chk_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
